// File: rtl/frame_seq_pkg.sv
// Shared types and defaults for the frame sequencer: FSM state, pixel word
// layout and the configuration legality check.
package frame_seq_pkg;

  localparam int CW_DEF         = 11;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PIX_W          = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Width must be a nonzero multiple of 4 so the packer sees whole groups.
  function automatic logic cfg_ok(input logic w_nz, input logic h_nz, input logic [1:0] w_lsb);
    return w_nz && h_nz && (w_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Renderer request/response channels plus the downstream pixel stream.
// master = sequencer side, slave = renderer/packer side.
interface frame_sequencer_if
  import frame_seq_pkg::*;
#(
  parameter int CW = CW_DEF
) ();

  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;

  logic          rsp_valid;
  logic [7:0]    rsp_r;
  logic [7:0]    rsp_g;
  logic [7:0]    rsp_b;

  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;
  logic          valid;
  logic          sof;
  logic          eol;
  logic          in_stream_ready;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready,
    input  rsp_valid, rsp_r, rsp_g, rsp_b,
    output r, g, b, valid, sof, eol,
    input  in_stream_ready
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready,
    output rsp_valid, rsp_r, rsp_g, rsp_b,
    input  r, g, b, valid, sof, eol,
    output in_stream_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rd_data whenever
// empty=0. Writes into a full FIFO are dropped.
module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic         full;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/frame_sequencer.sv
// Walks a width x height frame in raster order issuing pixel requests to the
// renderer, buffers in-order results and streams them out with sof/eol.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic          continuous,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] height,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err,
  frame_sequencer_if.master bus
);

  localparam int CRW = $clog2(FIFO_DEPTH + 1);

  seq_state_e     state;
  logic [CW-1:0]  w_m1;
  logic [CW-1:0]  h_m1;
  logic           cont_lat;
  logic [CW-1:0]  req_x;
  logic [CW-1:0]  req_y;
  logic [CW-1:0]  ox;
  logic [CW-1:0]  oy;
  logic [CRW-1:0] credits;

  logic           req_valid;
  logic           hs;
  logic           pop;
  logic           empty;
  logic           start_ok;
  logic           last_pop;
  pixel_t         head;

  assign start_ok  = (state == IDLE) && start &&
                     cfg_ok(width != '0, height != '0, width[1:0]);
  // A credit stands for a free FIFO slot, so responses can never overflow.
  assign req_valid = (state == ISSUE) && (credits != '0);
  assign hs        = req_valid && bus.req_ready;
  assign pop       = !empty && bus.in_stream_ready;
  assign last_pop  = pop && (ox == w_m1) && (oy == h_m1);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      cont_lat   <= 1'b0;
      w_m1       <= '0;
      h_m1       <= '0;
      req_x      <= '0;
      req_y      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            w_m1     <= width - CW'(1);
            h_m1     <= height - CW'(1);
            cont_lat <= continuous;
            req_x    <= '0;
            req_y    <= '0;
            cfg_err  <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end else if (start) begin
            cfg_err  <= 1'b1;
          end
        end
        ISSUE: begin
          if (hs) begin
            if (req_x == w_m1) begin
              req_x <= '0;
              if (req_y == h_m1) state <= DRAIN;
              else               req_y <= req_y + CW'(1);
            end else begin
              req_x <= req_x + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            frame_done <= 1'b1;
            req_x      <= '0;
            req_y      <= '0;
            if (cont_lat) begin
              state <= ISSUE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output raster position of the FIFO head; wraps naturally between frames.
  always_ff @(posedge aclk) begin
    if (!aresetn || start_ok) begin
      ox <= '0;
      oy <= '0;
    end else if (pop) begin
      if (ox == w_m1) begin
        ox <= '0;
        oy <= (oy == h_m1) ? '0 : oy + CW'(1);
      end else begin
        ox <= ox + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      credits <= CRW'(FIFO_DEPTH);
    end else begin
      case ({hs, pop})
        2'b10:   credits <= credits - CRW'(1);
        2'b01:   if (credits != CRW'(FIFO_DEPTH)) credits <= credits + CRW'(1);
        default: credits <= credits;
      endcase
    end
  end

  sync_fifo #(
    .W     (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (bus.rsp_valid),
    .wr_data ({bus.rsp_r, bus.rsp_g, bus.rsp_b}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty)
  );

  assign bus.req_valid = req_valid;
  assign bus.req_x     = req_x;
  assign bus.req_y     = req_y;
  assign bus.valid     = !empty;
  assign bus.r         = head.r;
  assign bus.g         = head.g;
  assign bus.b         = head.b;
  assign bus.sof       = !empty && (ox == '0) && (oy == '0);
  assign bus.eol       = !empty && (ox == w_m1);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench: renderer model with fixed latency returns R=x,G=y,B=x^y;
// a scoreboard of expected beats is filled on request and drained on output.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  localparam int CW = 11;
  localparam int FD = 8;

  logic          aclk       = 1'b0;
  logic          aresetn    = 1'b0;
  logic          start      = 1'b0;
  logic          continuous = 1'b0;
  logic [CW-1:0] width      = '0;
  logic [CW-1:0] height     = '0;
  logic          busy, frame_done, cfg_err;

  frame_sequencer_if #(.CW(CW)) bus ();

  frame_sequencer #(.CW(CW), .FIFO_DEPTH(FD)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .continuous (continuous),
    .width      (width),
    .height     (height),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .bus        (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } exp_t;

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } rsp_t;

  exp_t        sb[$];
  rsp_t        rq[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          lat = 1;
  int          isr_mode = 1;     // 0: stalled, 1: always ready, 2: random
  int          tw = 8, th = 2;
  int          ex = 0, ey = 0;
  int          req_cnt = 0, beat_cnt = 0, sof_cnt = 0, eol_cnt = 0, fd_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [25:0] held = '0;
  exp_t        e;
  rsp_t        t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Renderer, packer and scoreboard; all bench-side activity on the falling edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      sb.delete();
      rq.delete();
      bus.rsp_valid       = 1'b0;
      bus.rsp_r           = '0;
      bus.rsp_g           = '0;
      bus.rsp_b           = '0;
      bus.req_ready       = 1'b0;
      bus.in_stream_ready = 1'b0;
      stall_prev          = 1'b0;
      ex = 0;
      ey = 0;
    end else begin
      cyc++;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        t = rq.pop_front();
        bus.rsp_valid = 1'b1;
        bus.rsp_r = t.r;
        bus.rsp_g = t.g;
        bus.rsp_b = t.b;
      end else begin
        bus.rsp_valid = 1'b0;
      end
      bus.req_ready = 1'b1;
      case (isr_mode)
        0:       bus.in_stream_ready = 1'b0;
        1:       bus.in_stream_ready = 1'b1;
        default: bus.in_stream_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall_prev) begin
        check("stall_valid", bus.valid, 1);
        check("stall_data", {bus.r, bus.g, bus.b, bus.sof, bus.eol}, held);
      end
      if (bus.req_valid && bus.req_ready) begin
        check("req_x", bus.req_x, ex);
        check("req_y", bus.req_y, ey);
        rq.push_back('{due: cyc + lat, r: ex[7:0], g: ey[7:0], b: ex[7:0] ^ ey[7:0]});
        sb.push_back('{r: ex[7:0], g: ey[7:0], b: ex[7:0] ^ ey[7:0],
                       sof: (ex == 0 && ey == 0), eol: (ex == tw - 1)});
        req_cnt++;
        if (ex == tw - 1) begin
          ex = 0;
          ey = (ey == th - 1) ? 0 : ey + 1;
        end else begin
          ex++;
        end
      end
      if (bus.valid && bus.in_stream_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty_on_pop", 0, 1);
        end else begin
          e = sb.pop_front();
          check("pixel", {bus.r, bus.g, bus.b, bus.sof, bus.eol}, e);
        end
        beat_cnt++;
        if (bus.sof) sof_cnt++;
        if (bus.eol) eol_cnt++;
      end
      stall_prev = bus.valid && !bus.in_stream_ready;
      held       = {bus.r, bus.g, bus.b, bus.sof, bus.eol};
      if (frame_done) fd_cnt++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fd(input int n, input int budget, output int cycles);
    int target;
    target = fd_cnt + n;
    cycles = 0;
    while (fd_cnt < target && cycles < budget) begin
      @(posedge aclk); #1;
      cycles++;
    end
    check("frame_done_seen", fd_cnt >= target, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_valid"}, bus.req_valid, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_sof"}, bus.sof, 0);
    check({tag, "_eol"}, bus.eol, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  int r0, b0, s0, e0, f0, c;

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check_quiet("rst");
    check("rst_cfg_err", cfg_err, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 8x2, latency 3, always ready
    tw = 8; th = 2; lat = 3; isr_mode = 1;
    width = 8; height = 2; continuous = 0;
    r0 = req_cnt; b0 = beat_cnt; s0 = sof_cnt; e0 = eol_cnt; f0 = fd_cnt;
    pulse_start();
    check("t1_busy", busy, 1);
    wait_fd(1, 300, c);
    check("t1_busy_after", busy, 0);
    check("t1_reqs", req_cnt - r0, 16);
    check("t1_beats", beat_cnt - b0, 16);
    check("t1_sof", sof_cnt - s0, 1);
    check("t1_eol", eol_cnt - e0, 2);
    repeat (5) @(posedge aclk);
    #1;
    check("t1_fd_once", fd_cnt - f0, 1);
    check("t1_sb_drained", sb.size(), 0);

    // illegal configurations, then minimum legal 4x1
    width = 6; height = 2;
    r0 = req_cnt;
    pulse_start();
    check("t2_cfg_err_w6", cfg_err, 1);
    check("t2_busy_w6", busy, 0);
    repeat (5) @(posedge aclk);
    #1;
    check("t2_no_req", req_cnt - r0, 0);
    check("t2_busy_stays", busy, 0);
    width = 8; height = 0;
    pulse_start();
    check("t2_cfg_err_h0", cfg_err, 1);
    check("t2_busy_h0", busy, 0);
    tw = 4; th = 1; lat = 1;
    width = 4; height = 1;
    b0 = beat_cnt; s0 = sof_cnt; e0 = eol_cnt;
    pulse_start();
    check("t2_cfg_err_clr", cfg_err, 0);
    check("t2_busy", busy, 1);
    wait_fd(1, 100, c);
    check("t2_beats", beat_cnt - b0, 4);
    check("t2_sof", sof_cnt - s0, 1);
    check("t2_eol", eol_cnt - e0, 1);

    // downstream stalled: credits cap issue at FIFO depth
    tw = 8; th = 2; lat = 1; isr_mode = 0;
    width = 8; height = 2;
    r0 = req_cnt; b0 = beat_cnt;
    pulse_start();
    repeat (30) @(posedge aclk);
    #1;
    check("t3_reqs_capped", req_cnt - r0, FD);
    check("t3_req_valid_low", bus.req_valid, 0);
    check("t3_valid", bus.valid, 1);
    isr_mode = 1;
    wait_fd(1, 300, c);
    check("t3_reqs", req_cnt - r0, 16);
    check("t3_beats", beat_cnt - b0, 16);

    // random backpressure
    tw = 8; th = 4; lat = 2; isr_mode = 2;
    width = 8; height = 4;
    b0 = beat_cnt;
    pulse_start();
    wait_fd(1, 2000, c);
    check("t4_beats", beat_cnt - b0, 32);
    isr_mode = 1;
    repeat (3) @(posedge aclk);
    #1;

    // continuous 4x1
    tw = 4; th = 1; lat = 1;
    width = 4; height = 1; continuous = 1;
    s0 = sof_cnt;
    pulse_start();
    continuous = 0;
    wait_fd(1, 100, c);
    for (int k = 0; k < 3; k++) begin
      wait_fd(1, 100, c);
      check("t5_gap", c <= 7, 1);
    end
    check("t5_sof", sof_cnt - s0, 4);
    check("t5_busy", busy, 1);

    // reset to stop continuous mode
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check_quiet("rst2");
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // reset in the middle of an 8x2 frame
    tw = 8; th = 2; lat = 1;
    width = 8; height = 2;
    b0 = beat_cnt;
    pulse_start();
    c = 0;
    while (beat_cnt - b0 < 5 && c < 200) begin
      @(posedge aclk); #1;
      c++;
    end
    check("t6_reached_px5", beat_cnt - b0 >= 5, 1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check_quiet("t6_mid_rst");
    check("t6_cfg_err", cfg_err, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    b0 = beat_cnt; s0 = sof_cnt;
    pulse_start();
    wait_fd(1, 300, c);
    check("t6_beats", beat_cnt - b0, 16);
    check("t6_sof", sof_cnt - s0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
